// File: rtl/display7seg_pkg.sv
// display7seg_pkg
// Shared definitions for the multiplexed 7-segment display path:
//   - glyph constants for 0-F, blank and dash, segment order {g,f,e,d,c,b,a}
//   - handshake FSM state type
//   - pow10(): elaboration-time 10^n, used for the decimal overflow limit
package display7seg_pkg;

    localparam logic [6:0] GLYPH_0     = 7'b0111111;
    localparam logic [6:0] GLYPH_1     = 7'b0000110;
    localparam logic [6:0] GLYPH_2     = 7'b1011011;
    localparam logic [6:0] GLYPH_3     = 7'b1001111;
    localparam logic [6:0] GLYPH_4     = 7'b1100110;
    localparam logic [6:0] GLYPH_5     = 7'b1101101;
    localparam logic [6:0] GLYPH_6     = 7'b1111101;
    localparam logic [6:0] GLYPH_7     = 7'b0000111;
    localparam logic [6:0] GLYPH_8     = 7'b1111111;
    localparam logic [6:0] GLYPH_9     = 7'b1101111;
    localparam logic [6:0] GLYPH_A     = 7'b1110111;
    localparam logic [6:0] GLYPH_B     = 7'b1111100;
    localparam logic [6:0] GLYPH_C     = 7'b0111001;
    localparam logic [6:0] GLYPH_D     = 7'b1011110;
    localparam logic [6:0] GLYPH_E     = 7'b1111001;
    localparam logic [6:0] GLYPH_F     = 7'b1110001;
    localparam logic [6:0] GLYPH_BLANK = 7'b0000000;
    localparam logic [6:0] GLYPH_DASH  = 7'b1000000;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CONV   = 2'd1,
        ST_COMMIT = 2'd2
    } state_t;

    function automatic logic [63:0] pow10(input int unsigned n);
        logic [63:0] r;
        r = 64'd1;
        for (int unsigned i = 0; i < n; i++) begin
            r = r * 64'd10;
        end
        return r;
    endfunction

endpackage

// File: rtl/display7seg_mux_glyph.sv
// seg7_glyph
// Combinational digit-to-segment decoder, reusable by other display blocks.
//   i_digit : 4-bit digit value (0-F)
//   i_blank : 1 forces all segments off
//   i_dash  : 1 forces the dash glyph (takes priority over i_blank)
//   o_glyph : active-high segments {g,f,e,d,c,b,a}
module seg7_glyph
    import display7seg_pkg::*;
(
    input  logic [3:0] i_digit,
    input  logic       i_blank,
    input  logic       i_dash,
    output logic [6:0] o_glyph
);

    always_comb begin
        o_glyph = GLYPH_BLANK;
        if (i_dash) begin
            o_glyph = GLYPH_DASH;
        end else if (!i_blank) begin
            case (i_digit)
                4'h0: o_glyph = GLYPH_0;
                4'h1: o_glyph = GLYPH_1;
                4'h2: o_glyph = GLYPH_2;
                4'h3: o_glyph = GLYPH_3;
                4'h4: o_glyph = GLYPH_4;
                4'h5: o_glyph = GLYPH_5;
                4'h6: o_glyph = GLYPH_6;
                4'h7: o_glyph = GLYPH_7;
                4'h8: o_glyph = GLYPH_8;
                4'h9: o_glyph = GLYPH_9;
                4'hA: o_glyph = GLYPH_A;
                4'hB: o_glyph = GLYPH_B;
                4'hC: o_glyph = GLYPH_C;
                4'hD: o_glyph = GLYPH_D;
                4'hE: o_glyph = GLYPH_E;
                4'hF: o_glyph = GLYPH_F;
                default: o_glyph = GLYPH_BLANK;
            endcase
        end
    end

endmodule

// File: rtl/display7seg_mux.sv
// display7seg_mux
// Multiplexed multi-digit 7-segment driver. A value accepted through the
// load/busy handshake is converted to decimal (double dabble, WIDTH cycles)
// or hex (nibble split), committed atomically to the digit bank, and scanned
// onto one shared segment bus with one-hot digit enables.
//   clock_in, reset_n_in : clock, asynchronous active-low reset
//   load_in, value_in    : conversion request and value (accepted when !busy_out)
//   hex_in               : captured on accept, 1 = hex, 0 = decimal
//   blank_in             : live leading-zero blanking enable
//   busy_out             : conversion in progress
//   overflow_out         : last committed value did not fit in DIGITS
//   seg_out, an_out      : registered segment bus and digit enables
module display7seg_mux
    import display7seg_pkg::*;
#(
    parameter int unsigned DIGITS         = 4,
    parameter int unsigned WIDTH          = 14,
    parameter int unsigned SCAN_DIV       = 50000,
    parameter bit          SEG_ACTIVE_LOW = 1'b0,
    parameter bit          AN_ACTIVE_LOW  = 1'b0
) (
    input  logic              clock_in,
    input  logic              reset_n_in,
    input  logic              load_in,
    input  logic [WIDTH-1:0]  value_in,
    input  logic              hex_in,
    input  logic              blank_in,
    output logic              busy_out,
    output logic              overflow_out,
    output logic [6:0]        seg_out,
    output logic [DIGITS-1:0] an_out
);

    localparam int unsigned BW = 4 * DIGITS;
    localparam int unsigned CW = $clog2(WIDTH + 1);
    localparam int unsigned PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [63:0]       DEC_LIMIT  = pow10(DIGITS);
    localparam logic [CW-1:0]     LAST_SHIFT = CW'(WIDTH - 1);
    localparam logic [PW-1:0]     PRE_LAST   = PW'(SCAN_DIV - 1);
    localparam logic [IW-1:0]     IDX_LAST   = IW'(DIGITS - 1);
    localparam logic [6:0]        SEG_OFF    = SEG_ACTIVE_LOW ? '1 : '0;
    localparam logic [DIGITS-1:0] AN_OFF     = AN_ACTIVE_LOW ? '1 : '0;

    state_t              r_state;
    logic                r_busy;
    logic                r_hex;
    logic                r_ovf_pend;
    logic                r_ovf;
    logic [WIDTH-1:0]    r_value;
    logic [BW-1:0]       r_bcd;
    logic [CW-1:0]       r_cnt;
    logic [3:0]          r_digit [DIGITS];
    logic [PW-1:0]       r_pre;
    logic [IW-1:0]       r_idx;
    logic [6:0]          r_seg;
    logic [DIGITS-1:0]   r_an;

    logic                w_accept;
    logic                w_ovf_in;
    logic [BW-1:0]       w_bcd_adj;
    logic [BW-1:0]       w_bcd_next;
    logic [BW-1:0]       w_hex_digits;
    logic [DIGITS-1:0]   w_lead;
    logic                w_zero_above;
    logic                w_blank;
    logic [6:0]          w_glyph;
    logic [DIGITS-1:0]   w_onehot;

    assign w_accept = load_in & ~r_busy;

    // Both overflow tests are evaluated on the raw input at accept time so the
    // flag is ready to commit together with the digits.
    assign w_ovf_in = hex_in ? ((64'(value_in) >> BW) != 64'd0)
                             : (64'(value_in) >= DEC_LIMIT);

    always_comb begin
        w_bcd_adj = '0;
        for (int unsigned k = 0; k < DIGITS; k++) begin
            w_bcd_adj[4*k +: 4] = (r_bcd[4*k +: 4] >= 4'd5) ? r_bcd[4*k +: 4] + 4'd3
                                                            : r_bcd[4*k +: 4];
        end
    end

    // Shift left by one, dropping the top BCD bit and taking the value MSB.
    assign w_bcd_next   = BW'({w_bcd_adj, r_value[WIDTH-1]});
    assign w_hex_digits = BW'(r_value);

    always_ff @(posedge clock_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            r_state    <= ST_IDLE;
            r_busy     <= 1'b0;
            r_hex      <= 1'b0;
            r_ovf_pend <= 1'b0;
            r_ovf      <= 1'b0;
            r_value    <= '0;
            r_bcd      <= '0;
            r_cnt      <= '0;
            for (int unsigned k = 0; k < DIGITS; k++) begin
                r_digit[k] <= '0;
            end
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_value    <= value_in;
                        r_hex      <= hex_in;
                        r_ovf_pend <= w_ovf_in;
                        r_bcd      <= '0;
                        r_cnt      <= '0;
                        r_busy     <= 1'b1;
                        r_state    <= hex_in ? ST_COMMIT : ST_CONV;
                    end
                end
                ST_CONV: begin
                    r_bcd   <= w_bcd_next;
                    r_value <= r_value << 1;
                    r_cnt   <= r_cnt + CW'(1);
                    if (r_cnt == LAST_SHIFT) begin
                        r_state <= ST_COMMIT;
                    end
                end
                ST_COMMIT: begin
                    for (int unsigned k = 0; k < DIGITS; k++) begin
                        r_digit[k] <= r_hex ? w_hex_digits[4*k +: 4] : r_bcd[4*k +: 4];
                    end
                    r_ovf   <= r_ovf_pend;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clock_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            r_pre <= '0;
            r_idx <= '0;
        end else if (r_pre == PRE_LAST) begin
            r_pre <= '0;
            r_idx <= (r_idx == IDX_LAST) ? '0 : r_idx + IW'(1);
        end else begin
            r_pre <= r_pre + PW'(1);
        end
    end

    // w_lead[i] = digit i and every digit above it are zero; digit 0 never qualifies.
    always_comb begin
        w_lead       = '0;
        w_zero_above = 1'b1;
        for (int unsigned k = DIGITS - 1; k >= 1; k--) begin
            w_zero_above = w_zero_above & (r_digit[k] == 4'd0);
            w_lead[k]    = w_zero_above;
        end
    end

    assign w_blank  = blank_in & w_lead[r_idx] & ~r_ovf;
    assign w_onehot = DIGITS'(1) << r_idx;

    seg7_glyph u_glyph (
        .i_digit (r_digit[r_idx]),
        .i_blank (w_blank),
        .i_dash  (r_ovf),
        .o_glyph (w_glyph)
    );

    always_ff @(posedge clock_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            r_seg <= SEG_OFF;
            r_an  <= AN_OFF;
        end else begin
            r_seg <= SEG_ACTIVE_LOW ? ~w_glyph : w_glyph;
            r_an  <= AN_ACTIVE_LOW ? ~w_onehot : w_onehot;
        end
    end

    assign busy_out     = r_busy;
    assign overflow_out = r_ovf;
    assign seg_out      = r_seg;
    assign an_out       = r_an;

endmodule

// File: tb/tb_display7seg_mux.sv
// tb_display7seg_mux
// Randomised bench for display7seg_mux (DIGITS=4, WIDTH=14, SCAN_DIV=4).
// The reference model works from edge numbers and arithmetic digit
// extraction: accept/busy/commit times are derived from the accept edge,
// displayed digit index from the edge count, digits by division.
module tb_display7seg_mux;

    localparam int unsigned DIGITS   = 4;
    localparam int unsigned WIDTH    = 14;
    localparam int unsigned SCAN_DIV = 4;

    logic              clk   = 1'b0;
    logic              rst_n = 1'b1;
    logic              load  = 1'b0;
    logic              hex   = 1'b0;
    logic              blank = 1'b0;
    logic [WIDTH-1:0]  value = '0;
    logic              busy;
    logic              ovf;
    logic [6:0]        seg;
    logic [DIGITS-1:0] an;

    always #5 clk = ~clk;

    display7seg_mux #(
        .DIGITS         (DIGITS),
        .WIDTH          (WIDTH),
        .SCAN_DIV       (SCAN_DIV),
        .SEG_ACTIVE_LOW (1'b0),
        .AN_ACTIVE_LOW  (1'b0)
    ) dut (
        .clock_in     (clk),
        .reset_n_in   (rst_n),
        .load_in      (load),
        .value_in     (value),
        .hex_in       (hex),
        .blank_in     (blank),
        .busy_out     (busy),
        .overflow_out (ovf),
        .seg_out      (seg),
        .an_out       (an)
    );

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    logic [6:0] glyph_tab [16] = '{
        7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
        7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
        7'b1111111, 7'b1101111, 7'b1110111, 7'b1111100,
        7'b0111001, 7'b1011110, 7'b1111001, 7'b1110001
    };
    localparam logic [6:0] DASH = 7'b1000000;

    function automatic int unsigned model_digit(input int unsigned v, input bit h, input int unsigned i);
        int unsigned base;
        base = h ? 16 : 10;
        for (int unsigned j = 0; j < i; j++) v = v / base;
        return v % base;
    endfunction

    function automatic bit model_blank(input int unsigned v, input bit h, input int unsigned i);
        int unsigned p;
        if (i == 0) return 1'b0;
        p = 1;
        for (int unsigned j = 0; j < i; j++) p = p * (h ? 16 : 10);
        return v < p;
    endfunction

    // Reference model state; expected outputs describe the DUT after each edge.
    int          edge_n     = 0;
    int          busy_last  = -10;
    bit          pend_valid = 1'b0;
    int          pend_edge  = 0;
    int unsigned pend_val   = 0;
    bit          pend_hex   = 1'b0;
    int unsigned m_val      = 0;
    bit          m_hex      = 1'b0;
    bit          m_ovf      = 1'b0;
    logic        exp_busy   = 1'b0;
    logic        exp_ovf    = 1'b0;
    logic [6:0]  exp_seg    = 7'b0;
    logic [3:0]  exp_an     = 4'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            edge_n     = 0;
            busy_last  = -10;
            pend_valid = 1'b0;
            m_val      = 0;
            m_hex      = 1'b0;
            m_ovf      = 1'b0;
            exp_busy   = 1'b0;
            exp_ovf    = 1'b0;
            exp_seg    = 7'b0;
            exp_an     = 4'b0;
        end else begin
            int unsigned idx;
            edge_n++;
            // Display after this edge uses the state committed before it.
            idx    = ((edge_n - 1) / SCAN_DIV) % DIGITS;
            exp_an = 4'(1 << idx);
            if (m_ovf)                               exp_seg = DASH;
            else if (blank && model_blank(m_val, m_hex, idx)) exp_seg = 7'b0;
            else                                     exp_seg = glyph_tab[model_digit(m_val, m_hex, idx)];
            if (pend_valid && pend_edge == edge_n) begin
                m_val      = pend_val;
                m_hex      = pend_hex;
                m_ovf      = pend_hex ? (pend_val >= (1 << (4 * DIGITS))) : (pend_val >= 10 ** DIGITS);
                pend_valid = 1'b0;
            end
            if (load && (edge_n - 1 > busy_last)) begin
                pend_valid = 1'b1;
                pend_val   = int'(value);
                pend_hex   = hex;
                pend_edge  = edge_n + (hex ? 1 : WIDTH + 1);
                busy_last  = edge_n + (hex ? 0 : WIDTH);
            end
            exp_busy = (edge_n <= busy_last);
            exp_ovf  = m_ovf;
        end
    end

    bit mon_en = 1'b1;

    always @(negedge clk) begin
        if (mon_en) begin
            check_eq("busy", 32'(busy), 32'(exp_busy));
            check_eq("ovf",  32'(ovf),  32'(exp_ovf));
            check_eq("an",   32'(an),   32'(exp_an));
            check_eq("seg",  32'(seg),  32'(exp_seg));
        end
    end

    task automatic do_load(input int unsigned v, input bit h, input bit b);
        int cnt;
        @(negedge clk);
        value = WIDTH'(v);
        hex   = h;
        blank = b;
        load  = 1'b1;
        @(negedge clk);
        load = 1'b0;
        cnt  = busy ? 1 : 0;
        repeat (39) begin
            @(negedge clk);
            if (busy) cnt++;
        end
        check_eq(h ? "busy_len_hex" : "busy_len_dec", 32'(cnt), h ? 32'd1 : 32'(WIDTH + 1));
    endtask

    initial begin
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (40) @(negedge clk);

        do_load(1234, 1'b0, 1'b0);
        do_load(14'h3A7F, 1'b1, 1'b0);
        do_load(10000, 1'b0, 1'b0);
        do_load(0, 1'b0, 1'b1);
        do_load(9999, 1'b0, 1'b1);
        do_load(7, 1'b1, 1'b1);

        repeat (25) begin
            int unsigned v;
            case ($urandom % 6)
                0:       v = 9999;
                1:       v = 10000;
                2:       v = 16383;
                3:       v = $urandom % 10000;
                4:       v = $urandom % 100;
                default: v = $urandom % 16384;
            endcase
            do_load(v, 1'($urandom % 2), 1'($urandom % 2));
        end

        // load_in held high: accepts must fall every WIDTH+2 cycles.
        @(negedge clk);
        hex   = 1'b0;
        blank = 1'b1;
        load  = 1'b1;
        repeat (90) begin
            value = WIDTH'($urandom % 16384);
            @(negedge clk);
        end
        load = 1'b0;
        repeat (40) @(negedge clk);

        // Reset in the middle of a decimal conversion.
        @(negedge clk);
        value = WIDTH'(4321);
        hex   = 1'b0;
        load  = 1'b1;
        @(negedge clk);
        load = 1'b0;
        repeat (4) @(negedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_ovf",  32'(ovf),  32'd0);
        check_eq("rst_seg",  32'(seg),  32'd0);
        check_eq("rst_an",   32'(an),   32'd0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (5) @(negedge clk);
        do_load(4321, 1'b0, 1'b0);
        do_load(56, 1'b0, 1'b1);

        mon_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
